vegeta_weight_feeder_fp6: RTL and testbench

- Transmit side of the PE weight-load interface: turns dense FP6 weight groups into N:4 compressed (value, 2-bit index) beats.
- Shifts one tile of such beats into a vegeta_pe_fp6 column using weight_transferring and the double-buffer select i_wb.
- Sits between the weight SRAM read port (valid/ready stream) and the top row of the PE array.
- One tile = DEPTH output beats, i.e. one beat per PE row.

---
 rtl/vegeta_weight_feeder_fp6.sv | 191 +++++++++++++++++++
 tb/tb_vegeta_weight_feeder_fp6.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vegeta_weight_feeder_fp6.sv
// vegeta_weight_feeder_fp6
// Transmit side of the PE weight-load path. Takes dense FP6 weight groups from
// the weight SRAM stream and emits N:4 compressed (value, index) beats, one beat
// per PE row, into the top of a vegeta_pe_fp6 column.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   tile_start               start one tile load (sampled in IDLE only)
//   gemm_mode_in[1:0]        00 dense, 01 2:4, 10 1:4, 11 handled as 2:4
//   s_valid/s_ready/s_data   dense group stream, lane l element e at [(l*M+e)*6 +: 6]
//   weight_out               lane l slot j at [(l*BETA+j)*8 +: 8] = {meta, value}
//   weight_transferring_out  weight_out valid, PE column shifts this cycle
//   i_wb                     PE double-buffer half being loaded by this tile
//   gemm_mode_out            mode latched at tile_start
//   busy, tile_done          FILL/DONE indicator, one-cycle end-of-tile pulse
//   sparsity_err             sticky over-density flag
//
// Optional: define VEGETA_FEEDER_SPARSITY_CHECK_EN to flag sparse-mode groups
// carrying more nonzeros than the mode keeps. Undefined: sparsity_err is 0.
//
// state | meaning
// IDLE  | waiting for tile_start, stream stalled
// FILL  | accepting groups and emitting beats until DEPTH beats issued
// DONE  | tile_done pulse, buffer select flips on exit
module vegeta_weight_feeder_fp6 #(
    parameter int ALPHA          = 4,
    parameter int BETA           = 2,
    parameter int M              = 4,
    parameter int MUL_DATAWIDTH  = 6,
    parameter int META_DATA_SIZE = 2,
    parameter int DEPTH          = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 tile_start,
    input  logic [1:0]                                           gemm_mode_in,
    input  logic                                                 s_valid,
    output logic                                                 s_ready,
    input  logic [ALPHA*M*MUL_DATAWIDTH-1:0]                     s_data,
    output logic [ALPHA*BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] weight_out,
    output logic                                                 weight_transferring_out,
    output logic                                                 i_wb,
    output logic [1:0]                                           gemm_mode_out,
    output logic                                                 busy,
    output logic                                                 tile_done,
    output logic                                                 sparsity_err
);
    localparam int SLOT_W = MUL_DATAWIDTH + META_DATA_SIZE;
    localparam int BEAT_W = ALPHA * BETA * SLOT_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic                r_half_valid;
    logic [BEAT_W-1:0]   r_half;
    logic [BEAT_W-1:0]   r_weight;
    logic                r_xfer;
    logic                r_wb;
    logic [1:0]          r_mode;
    logic                r_tile_done;

    logic [BEAT_W-1:0]   w_sparse_beat;
    logic [BEAT_W-1:0]   w_dense_a;
    logic [BEAT_W-1:0]   w_dense_b;
    logic                w_accept;
`ifdef VEGETA_FEEDER_SPARSITY_CHECK_EN
    logic                w_over;
    logic                r_err;
`endif

    // Beat counter tracks beats launched into the output register. Because the
    // tile length is even, a dense group (two beats) never straddles DEPTH.
    assign s_ready  = (r_state == ST_FILL) && !r_half_valid && (r_beat_cnt < LAST_CNT);
    assign w_accept = s_valid && s_ready;

    // Sign bit is ignored in the zero test so -0 is dropped like +0.
    always_comb begin
        int nslots;
        int nnz;
        logic [MUL_DATAWIDTH-1:0] elem;
        w_sparse_beat = '0;
        w_dense_a     = '0;
        w_dense_b     = '0;
        nslots        = (r_mode == 2'b10) ? 1 : 2;
        nnz           = 0;
        elem          = '0;
`ifdef VEGETA_FEEDER_SPARSITY_CHECK_EN
        w_over        = 1'b0;
`endif
        for (int l = 0; l < ALPHA; l++) begin
            nnz = 0;
            for (int e = 0; e < M; e++) begin
                elem = s_data[(l*M+e)*MUL_DATAWIDTH +: MUL_DATAWIDTH];
                if (elem[MUL_DATAWIDTH-2:0] != '0) begin
                    if (nnz < nslots)
                        w_sparse_beat[(l*BETA+nnz)*SLOT_W +: SLOT_W] = {META_DATA_SIZE'(e), elem};
                    nnz = nnz + 1;
                end
            end
`ifdef VEGETA_FEEDER_SPARSITY_CHECK_EN
            if (nnz > nslots)
                w_over = 1'b1;
`endif
            for (int j = 0; j < BETA; j++) begin
                w_dense_a[(l*BETA+j)*SLOT_W +: SLOT_W] =
                    {META_DATA_SIZE'(j), s_data[(l*M+j)*MUL_DATAWIDTH +: MUL_DATAWIDTH]};
                w_dense_b[(l*BETA+j)*SLOT_W +: SLOT_W] =
                    {META_DATA_SIZE'(j+BETA), s_data[(l*M+j+BETA)*MUL_DATAWIDTH +: MUL_DATAWIDTH]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_half_valid <= 1'b0;
            r_half       <= '0;
            r_weight     <= '0;
            r_xfer       <= 1'b0;
            r_wb         <= 1'b0;
            r_mode       <= 2'b00;
            r_tile_done  <= 1'b0;
`ifdef VEGETA_FEEDER_SPARSITY_CHECK_EN
            r_err        <= 1'b0;
`endif
        end else begin
            r_xfer      <= 1'b0;
            r_tile_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tile_start) begin
                        r_mode       <= gemm_mode_in;
                        r_beat_cnt   <= '0;
                        r_half_valid <= 1'b0;
                        r_state      <= ST_FILL;
`ifdef VEGETA_FEEDER_SPARSITY_CHECK_EN
                        r_err        <= 1'b0;
`endif
                    end
                end
                ST_FILL: begin
                    if (r_half_valid) begin
                        r_weight     <= r_half;
                        r_xfer       <= 1'b1;
                        r_half_valid <= 1'b0;
                        r_beat_cnt   <= r_beat_cnt + 1'b1;
                    end else if (w_accept) begin
                        if (r_mode == 2'b00) begin
                            r_weight     <= w_dense_a;
                            r_half       <= w_dense_b;
                            r_half_valid <= 1'b1;
                        end else begin
                            r_weight     <= w_sparse_beat;
`ifdef VEGETA_FEEDER_SPARSITY_CHECK_EN
                            if (w_over)
                                r_err <= 1'b1;
`endif
                        end
                        r_xfer     <= 1'b1;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end else if (r_beat_cnt == LAST_CNT) begin
                        r_state     <= ST_DONE;
                        r_tile_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_wb    <= ~r_wb;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign weight_out              = r_weight;
    assign weight_transferring_out = r_xfer;
    assign i_wb                    = r_wb;
    assign gemm_mode_out           = r_mode;
    assign busy                    = (r_state != ST_IDLE);
    assign tile_done               = r_tile_done;
`ifdef VEGETA_FEEDER_SPARSITY_CHECK_EN
    assign sparsity_err            = r_err;
`else
    assign sparsity_err            = 1'b0;
`endif

endmodule

// File: tb/tb_vegeta_weight_feeder_fp6.sv
`timescale 1ns/1ps
module tb_vegeta_weight_feeder_fp6;
    localparam int ALPHA = 4;
    localparam int BETA  = 2;
    localparam int M     = 4;
    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int IN_W  = ALPHA * M * DW;
    localparam int OUT_W = ALPHA * BETA * 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tile_start = 1'b0;
    logic [1:0]       gemm_mode_in = 2'b00;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [IN_W-1:0]  s_data = '0;
    logic [OUT_W-1:0] weight_out;
    logic             weight_transferring_out;
    logic             i_wb;
    logic [1:0]       gemm_mode_out;
    logic             busy;
    logic             tile_done;
    logic             sparsity_err;

    always #5 clk = ~clk;

    vegeta_weight_feeder_fp6 dut (
        .clk(clk), .rst_n(rst_n), .tile_start(tile_start), .gemm_mode_in(gemm_mode_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .weight_out(weight_out),
        .weight_transferring_out(weight_transferring_out), .i_wb(i_wb),
        .gemm_mode_out(gemm_mode_out), .busy(busy), .tile_done(tile_done),
        .sparsity_err(sparsity_err)
    );

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [IN_W-1:0]  grp_q[$];
    logic [15:0]      lane0_log[$];
    logic [OUT_W-1:0] last_w = '0;
    logic [1:0]       cur_mode = 2'b00;
    bit               hs_prev = 1'b0;
    bit               err_set_pend = 1'b0;
    bit               err_clr_pend = 1'b0;
    bit               exp_err = 1'b0;
    bit               exp_wb = 1'b0;
    bit               tdone_seen = 1'b0;
    int               cyc = 0;
    int               last_x_cyc = 0;
    int               tile_beats = 0;
    int               tdone_cnt = 0;
    bit               vpat[0:15];
    int               vlen = 0;
    bit               rdy_log[0:7];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] rand_group();
        logic [IN_W-1:0] r;
        for (int k = 0; k < IN_W/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [IN_W-1:0] mk_group(input logic [5:0] e0, input logic [5:0] e1,
                                                  input logic [5:0] e2, input logic [5:0] e3,
                                                  input bit rand_rest);
        logic [IN_W-1:0] r;
        r = rand_rest ? rand_group() : '0;
        r[23:0] = {e3, e2, e1, e0};
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] dense_beat(input logic [IN_W-1:0] g, input int half);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int l = 0; l < ALPHA; l++)
            for (int j = 0; j < BETA; j++)
                r[(l*BETA+j)*8 +: 8] = {2'(half*BETA+j), g[(l*M+half*BETA+j)*DW +: DW]};
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] sparse_beat(input logic [1:0] mode, input logic [IN_W-1:0] g,
                                                      output bit over);
        logic [OUT_W-1:0] r;
        logic [DW-1:0]    v;
        int               keep;
        int               idx[$];
        r    = '0;
        over = 1'b0;
        keep = (mode == 2'b10) ? 1 : 2;
        for (int l = 0; l < ALPHA; l++) begin
            idx.delete();
            for (int e = 0; e < M; e++) begin
                v = g[(l*M+e)*DW +: DW];
                if (v[4:0] != 5'd0) idx.push_back(e);
            end
            if (idx.size() > keep) over = 1'b1;
            for (int j = 0; j < keep && j < idx.size(); j++)
                r[(l*BETA+j)*8 +: 8] = {2'(idx[j]), g[(l*M+idx[j])*DW +: DW]};
        end
        return r;
    endfunction

    // Advance one clock and check everything visible in the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (err_clr_pend) exp_err = 1'b0;
        if (err_set_pend) exp_err = 1'b1;
        err_clr_pend = 1'b0;
        err_set_pend = 1'b0;
        if (cur_mode != 2'b00)
            check_val("xfer_lat", 64'(weight_transferring_out), 64'(hs_prev));
        hs_prev = 1'b0;
        if (weight_transferring_out) begin
            tile_beats++;
            last_x_cyc = cyc;
            if (exp_q.size() == 0)
                check_val("unexpected_beat", 64'(weight_transferring_out), 64'd0);
            else
                check_val("beat", 64'(weight_out), 64'(exp_q.pop_front()));
            last_w = weight_out;
            lane0_log.push_back(weight_out[15:0]);
        end else begin
            check_val("hold", 64'(weight_out), 64'(last_w));
        end
        check_val("sparsity_err", 64'(sparsity_err), 64'(exp_err));
        if (tile_done) begin
            tdone_cnt++;
            tdone_seen = 1'b1;
            check_val("tdone_gap", 64'(cyc - last_x_cyc), 64'd1);
            check_val("tile_beats", 64'(tile_beats), 64'(DEPTH));
            tile_beats = 0;
        end
    endtask

    task automatic run_tile(input logic [1:0] mode, input int abort_after, input bit poke);
        logic [IN_W-1:0]  g;
        logic [OUT_W-1:0] b;
        bit               hs;
        bit               over;
        check_val("idle_ready", 64'(s_ready), 64'd0);
        tile_start   = 1'b1;
        gemm_mode_in = mode;
        s_valid      = 1'b0;
        cur_mode     = mode;
        err_clr_pend = 1'b1;
        tdone_seen   = 1'b0;
        tick();
        tile_start   = poke;
        gemm_mode_in = poke ? ~mode : mode;
        check_val("mode_out", 64'(gemm_mode_out), 64'(mode));
        check_val("busy_fill", 64'(busy), 64'd1);
        for (int i = 0; i < 64 && !tdone_seen; i++) begin
            if (abort_after > 0 && tile_beats >= abort_after) break;
            s_valid = (i < vlen) ? vpat[i] : 1'b1;
            g = (grp_q.size() > 0) ? grp_q[0] : rand_group();
            s_data = g;
            hs = s_valid && s_ready;
            if (i < 8) rdy_log[i] = s_ready;
            if (hs) begin
                if (grp_q.size() > 0) void'(grp_q.pop_front());
                if (mode == 2'b00) begin
                    exp_q.push_back(dense_beat(g, 0));
                    exp_q.push_back(dense_beat(g, 1));
                end else begin
                    b = sparse_beat(mode, g, over);
                    exp_q.push_back(b);
`ifdef VEGETA_FEEDER_SPARSITY_CHECK_EN
                    if (over) err_set_pend = 1'b1;
`endif
                end
            end
            hs_prev = hs;
            tick();
        end
        if (abort_after == 0) begin
            check_val("tile_done_seen", 64'(tdone_seen), 64'd1);
            s_valid    = 1'b0;
            tile_start = poke;
            tick();
            tile_start = 1'b0;
            exp_wb     = ~exp_wb;
            check_val("i_wb", 64'(i_wb), 64'(exp_wb));
            check_val("busy_idle", 64'(busy), 64'd0);
            check_val("mode_hold", 64'(gemm_mode_out), 64'(mode));
            check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tdone_before;
        // Reset values
        #12;
        check_val("rst_weight", 64'(weight_out), 64'd0);
        check_val("rst_xfer", 64'(weight_transferring_out), 64'd0);
        check_val("rst_wb", 64'(i_wb), 64'd0);
        check_val("rst_mode", 64'(gemm_mode_out), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_tdone", 64'(tile_done), 64'd0);
        check_val("rst_err", 64'(sparsity_err), 64'd0);
        check_val("rst_ready", 64'(s_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Dense: two groups produce four beats, s_ready 1,0,1,0
        lane0_log.delete();
        grp_q.push_back(mk_group(6'd1, 6'd2, 6'd3, 6'd4, 1'b1));
        grp_q.push_back(mk_group(6'd1, 6'd2, 6'd3, 6'd4, 1'b1));
        vlen = 0;
        run_tile(2'b00, 0, 1'b0);
        check_val("dense_rdy0", 64'(rdy_log[0]), 64'd1);
        check_val("dense_rdy1", 64'(rdy_log[1]), 64'd0);
        check_val("dense_rdy2", 64'(rdy_log[2]), 64'd1);
        check_val("dense_rdy3", 64'(rdy_log[3]), 64'd0);
        check_val("dense_lane0_a", 64'(lane0_log[0]), 64'h4201);
        check_val("dense_lane0_b", 64'(lane0_log[1]), 64'hC483);
        check_val("dense_lane0_c", 64'(lane0_log[2]), 64'h4201);
        check_val("dense_lane0_d", 64'(lane0_log[3]), 64'hC483);

        // 2:4 basic group
        lane0_log.delete();
        grp_q.push_back(mk_group(6'd0, 6'd5, 6'd0, 6'd7, 1'b1));
        run_tile(2'b01, 0, 1'b0);
        check_val("s24_lane0", 64'(lane0_log[0]), 64'hC745);

        // 1:4 with -0 element and an over-dense group
        lane0_log.delete();
        grp_q.push_back(mk_group(6'd0, 6'd0, 6'h20, 6'd9, 1'b0));
        grp_q.push_back(mk_group(6'd1, 6'd2, 6'd0, 6'd0, 1'b0));
        grp_q.push_back('0);
        grp_q.push_back('0);
        run_tile(2'b10, 0, 1'b0);
        check_val("s14_lane0_a", 64'(lane0_log[0]), 64'h00C9);
        check_val("s14_lane0_b", 64'(lane0_log[1]), 64'h0001);
`ifdef VEGETA_FEEDER_SPARSITY_CHECK_EN
        check_val("s14_err_sticky", 64'(sparsity_err), 64'd1);
`else
        check_val("s14_err_off", 64'(sparsity_err), 64'd0);
`endif

        // Bubbles on s_valid in 2:4
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1;
        vpat[4] = 1; vpat[5] = 0; vpat[6] = 1;
        vlen = 7;
        tdone_before = tdone_cnt;
        run_tile(2'b01, 0, 1'b0);
        vlen = 0;
        repeat (3) tick();
        check_val("bubble_tdone_once", 64'(tdone_cnt - tdone_before), 64'd1);

        // Reset in the middle of FILL after two beats
        run_tile(2'b01, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_weight", 64'(weight_out), 64'd0);
        check_val("mid_rst_xfer", 64'(weight_transferring_out), 64'd0);
        check_val("mid_rst_wb", 64'(i_wb), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_mode", 64'(gemm_mode_out), 64'd0);
        check_val("mid_rst_tdone", 64'(tile_done), 64'd0);
        check_val("mid_rst_err", 64'(sparsity_err), 64'd0);
        exp_q.delete();
        grp_q.delete();
        last_w       = '0;
        tile_beats   = 0;
        exp_wb       = 1'b0;
        exp_err      = 1'b0;
        err_set_pend = 1'b0;
        err_clr_pend = 1'b0;
        hs_prev      = 1'b0;
        s_valid      = 1'b0;
        cur_mode     = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_tile(2'b01, 0, 1'b0);

        // tile_start held through FILL and DONE; back-to-back tiles flip i_wb
        run_tile(2'b11, 0, 1'b1);
        run_tile(2'b01, 0, 1'b1);
        run_tile(2'b00, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
